// File: rtl/exec_logic_shift.sv
// Logic execution unit: AND/OR/NOT/XOR in one cycle plus an iterative shift/rotate engine.
// Define EXEC_LOGIC_SHIFT_BARREL_EN to replace the iterative engine with a single-cycle barrel shifter.
module exec_logic_shift #(
  parameter int W_OPR      = 16,
  parameter int W_FLAGS    = 4,
  parameter int SHIFT_STEP = 1
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [2:0]         select_i,
  input  logic [W_OPR-1:0]   opr0_i,
  input  logic [W_OPR-1:0]   opr1_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [W_OPR-1:0]   result_o,
  output logic [W_FLAGS-1:0] flags_o,
  output logic [1:0]         state_o
);

  // Handshake: an op is accepted on a rising edge with in_valid_i & in_ready_o (IDLE only);
  // a result is consumed on a rising edge with out_valid_o & out_ready_i; flush_i overrides both.

  localparam int W_SHAMT = $clog2(W_OPR);

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_SLL = 3'd4;
  localparam logic [2:0] OP_SRL = 3'd5;
  localparam logic [2:0] OP_SRA = 3'd6;
  localparam logic [2:0] OP_ROL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [W_SHAMT-1:0] amt_in;
  logic               accept;
  logic               imm_op;
  logic [W_OPR-1:0]   imm_res;
  logic [W_FLAGS-1:0] imm_flags;

  logic [2:0]         sh_op;
  logic [W_OPR-1:0]   sh_in;
  logic [W_SHAMT-1:0] sh_n;
  logic               sh_msb;
  logic [W_SHAMT-1:0] sh_inv;
  logic [W_SHAMT-1:0] sh_nm1;
  logic [W_OPR-1:0]   sh_res;
  logic               sh_c;
  logic [W_FLAGS-1:0] sh_flags;

  assign amt_in = opr1_i[W_SHAMT-1:0];
  assign accept = (state == S_IDLE) && in_valid_i && !flush_i;
  // Logic ops and zero-amount shifts complete straight from the input operands.
  assign imm_op = !select_i[2] || (amt_in == '0);

`ifdef EXEC_LOGIC_SHIFT_BARREL_EN
  assign sh_op  = select_i;
  assign sh_in  = opr0_i;
  assign sh_n   = amt_in;
  assign sh_msb = opr0_i[W_OPR-1];
`else
  logic [W_OPR-1:0]   sh_val_r;
  logic [W_SHAMT-1:0] rem_r;
  logic [2:0]         op_r;
  logic               msb_r;
  logic [W_SHAMT-1:0] step;
  logic               last_step;

  assign step      = (rem_r < W_SHAMT'(SHIFT_STEP)) ? rem_r : W_SHAMT'(SHIFT_STEP);
  assign last_step = (rem_r == step);
  assign sh_op     = op_r;
  assign sh_in     = sh_val_r;
  assign sh_n      = step;
  assign sh_msb    = msb_r;
`endif

  always_comb begin
    imm_res = opr0_i;
    case (select_i)
      OP_AND:  imm_res = opr0_i & opr1_i;
      OP_OR:   imm_res = opr0_i | opr1_i;
      OP_NOT:  imm_res = ~opr0_i;
      OP_XOR:  imm_res = opr0_i ^ opr1_i;
      default: imm_res = opr0_i;
    endcase
    imm_flags = {1'b0, imm_res[W_OPR-1], ~|imm_res, 1'b0};
  end

  // Shifter core; sh_n is nonzero whenever its output is used. Carry is the last bit out.
  always_comb begin
    sh_inv = W_SHAMT'(W_OPR - int'(sh_n));
    sh_nm1 = sh_n - W_SHAMT'(1);
    sh_res = sh_in;
    sh_c   = 1'b0;
    case (sh_op)
      OP_SLL: begin
        sh_res = sh_in << sh_n;
        sh_c   = sh_in[sh_inv];
      end
      OP_SRL: begin
        sh_res = sh_in >> sh_n;
        sh_c   = sh_in[sh_nm1];
      end
      OP_SRA: begin
        sh_res = W_OPR'($signed(sh_in) >>> sh_n);
        sh_c   = sh_in[sh_nm1];
      end
      OP_ROL: begin
        sh_res = (sh_in << sh_n) | (sh_in >> sh_inv);
        sh_c   = sh_res[0];
      end
      default: begin
        sh_res = sh_in;
        sh_c   = 1'b0;
      end
    endcase
    sh_flags = {(sh_op == OP_SLL) && (sh_res[W_OPR-1] != sh_msb),
                sh_res[W_OPR-1], ~|sh_res, sh_c};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (in_valid_i) begin
`ifdef EXEC_LOGIC_SHIFT_BARREL_EN
          state_nxt = S_DONE;
`else
          state_nxt = imm_op ? S_DONE : S_BUSY;
`endif
        end
      end
      S_BUSY: begin
`ifndef EXEC_LOGIC_SHIFT_BARREL_EN
        if (last_step) state_nxt = S_DONE;
`endif
      end
      S_DONE: begin
        if (out_ready_i) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (flush_i) state_nxt = S_IDLE;
  end

  always_comb begin
    in_ready_o  = (state == S_IDLE);
    out_valid_o = (state == S_DONE);
    state_o     = state;
  end

  // Datapath: operands are captured only on accept; flush leaves result_o/flags_o untouched.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      result_o <= '0;
      flags_o  <= '0;
`ifndef EXEC_LOGIC_SHIFT_BARREL_EN
      sh_val_r <= '0;
      rem_r    <= '0;
      op_r     <= OP_AND;
      msb_r    <= 1'b0;
`endif
    end else if (accept) begin
      if (imm_op) begin
        result_o <= imm_res;
        flags_o  <= imm_flags;
      end else begin
`ifdef EXEC_LOGIC_SHIFT_BARREL_EN
        result_o <= sh_res;
        flags_o  <= sh_flags;
`else
        sh_val_r <= opr0_i;
        rem_r    <= amt_in;
        op_r     <= select_i;
        msb_r    <= opr0_i[W_OPR-1];
`endif
      end
    end
`ifndef EXEC_LOGIC_SHIFT_BARREL_EN
    else if ((state == S_BUSY) && !flush_i) begin
      sh_val_r <= sh_res;
      rem_r    <= rem_r - step;
      if (last_step) begin
        result_o <= sh_res;
        flags_o  <= sh_flags;
      end
    end
`endif
  end

endmodule

// File: tb/tb_exec_logic_shift.sv
// Directed bench for exec_logic_shift: logic ops, shifts, backpressure, flush and async reset.
module tb_exec_logic_shift;

  localparam int W    = 16;
  localparam int STEP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    sel;
  logic [W-1:0]  opr0;
  logic [W-1:0]  opr1;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic [3:0]    flags;
  logic [1:0]    state_dbg;

  int checks   = 0;
  int failures = 0;

  exec_logic_shift #(.W_OPR(W), .W_FLAGS(4), .SHIFT_STEP(STEP)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .select_i   (sel),
    .opr0_i     (opr0),
    .opr1_i     (opr1),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .result_o   (result),
    .flags_o    (flags),
    .state_o    (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [2:0] s, input logic [W-1:0] b);
    int amt;
    amt = int'(b[3:0]);
`ifdef EXEC_LOGIC_SHIFT_BARREL_EN
    return 1;
`else
    if (!s[2] || amt == 0) return 1;
    return 1 + (amt + STEP - 1) / STEP;
`endif
  endfunction

  // Issue one op from IDLE, scramble operands after accept, then check latency/result/flags.
  task automatic do_op(input string tag, input logic [2:0] s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] er, input logic [3:0] ef);
    int lat;
    sel = s; opr0 = a; opr1 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    opr0 = W'($urandom_range(0, 65535));
    opr1 = W'($urandom_range(0, 65535));
    sel  = 3'($urandom_range(0, 7));
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"},    lat,      exp_lat(s, b));
    check({tag, "_res"},    result,   er);
    check({tag, "_flags"},  flags,    ef);
    check({tag, "_nready"}, in_ready, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drain"},  {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sel = 3'd0; opr0 = '0; opr1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", in_ready,  1'b1);
    check("reset_valid", out_valid, 1'b0);
    check("reset_res",   result,    16'h0000);
    check("reset_flags", flags,     4'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("and",     3'd0, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0100);
    do_op("or0",     3'd1, 16'h0000, 16'h0000, 16'h0000, 4'b0010);
    do_op("not",     3'd2, 16'hFFFF, 16'h1234, 16'h0000, 4'b0010);
    do_op("xor",     3'd3, 16'hA5A5, 16'h0F0F, 16'hAAAA, 4'b0100);
    do_op("sll1",    3'd4, 16'h4001, 16'h0001, 16'h8002, 4'b1100);
    do_op("sll1c",   3'd4, 16'h8001, 16'h0001, 16'h0002, 4'b1001);
    do_op("sra15",   3'd6, 16'h8000, 16'h000F, 16'hFFFF, 4'b0100);
    do_op("rol1",    3'd7, 16'h8001, 16'h0001, 16'h0003, 4'b0001);
    do_op("srl4",    3'd5, 16'h00F8, 16'hFF04, 16'h000F, 4'b0001);
    do_op("sll0",    3'd4, 16'h8000, 16'hFFF0, 16'h8000, 4'b0100);
    do_op("rol8",    3'd7, 16'h1234, 16'h0008, 16'h3412, 4'b0000);
    do_op("sll15",   3'd4, 16'h0001, 16'h000F, 16'h8000, 4'b1100);
    do_op("srl15",   3'd5, 16'hFFFF, 16'h000F, 16'h0001, 4'b0001);
    do_op("rol15",   3'd7, 16'h8000, 16'h000F, 16'h4000, 4'b0000);

    // Backpressure: result must hold while new requests are offered and ignored.
    sel = 3'd0; opr0 = 16'h0FF0; opr1 = 16'h00FF; in_valid = 1'b1;
    @(posedge clk); #1;
    sel = 3'd3; opr0 = 16'hFFFF; opr1 = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1'b1);
      check("bp_ready", in_ready,  1'b0);
      check("bp_res",   result,    16'h00F0);
      check("bp_flags", flags,     4'b0000);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_drain", {out_valid, in_ready}, 2'b01);
    @(posedge clk); #1;
    check("bp_no_accept", {out_valid, in_ready, result}, {2'b01, 16'h00F0});

    // Flush during the long SLL by 15.
    sel = 3'd4; opr0 = 16'h0001; opr1 = 16'h000F; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_state", {out_valid, in_ready}, 2'b01);
`ifdef EXEC_LOGIC_SHIFT_BARREL_EN
    check("flush_res",   {result, flags}, {16'h8000, 4'b1100});
`else
    check("flush_res",   {result, flags}, {16'h00F0, 4'b0000});
`endif
    repeat (6) @(posedge clk);
    #1;
    check("flush_quiet", {out_valid, in_ready}, 2'b01);

    // flush_i beats in_valid_i in IDLE.
    sel = 3'd1; opr0 = 16'h1111; opr1 = 16'h2222; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_wins", {out_valid, in_ready}, 2'b01);
    @(posedge clk); #1;
    check("flush_wins2", out_valid, 1'b0);

    // Asynchronous reset in the middle of a shift.
    sel = 3'd6; opr0 = 16'h8000; opr1 = 16'h000F; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", in_ready,  1'b1);
    check("arst_valid", out_valid, 1'b0);
    check("arst_res",   result,    16'h0000);
    check("arst_flags", flags,     4'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("arst_quiet", {out_valid, in_ready}, 2'b01);

    do_op("post_rst", 3'd4, 16'h0003, 16'h0002, 16'h000C, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
